// File: rtl/alu_seq.sv
// Multi-cycle MIPS ALU with valid/ready handshakes, iterative unsigned multiplier
// and an optional restoring divider (enabled by defining ALU_DIV_EN).
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 zero,
  output logic                 err
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MULU = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_BEQ  = 4'b0111;
  localparam logic [3:0] OP_BNE  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'b1010;
`endif

  localparam logic [WIDTH-1:0]   HALF_ZERO = {WIDTH{1'b0}};
  localparam logic [2*WIDTH-1:0] FULL_ZERO = {(2*WIDTH){1'b0}};
  localparam logic [CNT_W-1:0]   CNT_INIT  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t               state_r;
  logic [CNT_W-1:0]     count_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]     a_r;
  logic [2*WIDTH-1:0]   result_r;
  logic                 zero_r;
  logic                 err_r;
  logic                 out_valid_r;

  logic                 xfer_s;
  logic                 is_multi_s;
  logic [2*WIDTH-1:0]   sc_result_s;
  logic                 sc_zero_s;
  logic                 sc_err_s;
  logic [2*WIDTH-1:0]   acc_init_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH-1:0]   step_next_s;

`ifdef ALU_DIV_EN
  logic                 div_r;
  logic [WIDTH-1:0]     b_r;
  logic [WIDTH:0]       div_sh_s;
  logic                 div_ge_s;
  logic [WIDTH-1:0]     div_rem_s;
`endif

  assign in_ready  = (state_r == S_IDLE) | ((state_r == S_DONE) & out_ready);
  assign xfer_s    = in_valid & in_ready;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign zero      = zero_r;
  assign err       = err_r;

  // Decode the request: single-cycle result/flags, or flag a multi-cycle op.
  always_comb begin
    sc_result_s = FULL_ZERO;
    sc_err_s    = 1'b0;
    is_multi_s  = 1'b0;
    case (op)
      OP_ADD:  sc_result_s = {HALF_ZERO, a + b};
      OP_SUB:  sc_result_s = {HALF_ZERO, a - b};
      OP_AND:  sc_result_s = {HALF_ZERO, a & b};
      OP_OR:   sc_result_s = {HALF_ZERO, a | b};
      OP_XOR:  sc_result_s = {HALF_ZERO, a ^ b};
      OP_SLT:  sc_result_s = {{(2*WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: sc_result_s = {{(2*WIDTH-1){1'b0}}, (a < b)};
      OP_BEQ:  sc_result_s = FULL_ZERO;
      OP_BNE:  sc_result_s = FULL_ZERO;
      OP_MULU: is_multi_s  = 1'b1;
`ifdef ALU_DIV_EN
      OP_DIVU: is_multi_s  = 1'b1;
`endif
      default: sc_err_s    = 1'b1;
    endcase
    if (op == OP_BEQ) begin
      sc_zero_s = (a == b);
    end else if (op == OP_BNE) begin
      sc_zero_s = (a != b);
    end else if (sc_err_s) begin
      sc_zero_s = 1'b0;
    end else begin
      sc_zero_s = (sc_result_s == FULL_ZERO);
    end
  end

  // Iteration datapath: acc holds {partial product, remaining multiplier}
  // for MULU, or {partial remainder, dividend/quotient bits} for DIVU.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, (acc_r[0] ? a_r : HALF_ZERO)};
    step_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    acc_init_s  = {HALF_ZERO, b};
`ifdef ALU_DIV_EN
    div_sh_s  = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_ge_s  = (div_sh_s >= {1'b0, b_r});
    div_rem_s = div_ge_s ? (div_sh_s[WIDTH-1:0] - b_r) : div_sh_s[WIDTH-1:0];
    if (div_r) begin
      step_next_s = {div_rem_s, acc_r[WIDTH-2:0], div_ge_s};
    end else begin
      step_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end
    if (op == OP_DIVU) begin
      acc_init_s = {HALF_ZERO, a};
    end else begin
      acc_init_s = {HALF_ZERO, b};
    end
`endif
  end

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      count_r     <= {CNT_W{1'b0}};
      acc_r       <= FULL_ZERO;
      a_r         <= HALF_ZERO;
      result_r    <= FULL_ZERO;
      zero_r      <= 1'b0;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
`ifdef ALU_DIV_EN
      div_r       <= 1'b0;
      b_r         <= HALF_ZERO;
`endif
    end else if (xfer_s) begin
      if (is_multi_s) begin
        state_r     <= S_BUSY;
        count_r     <= CNT_INIT;
        acc_r       <= acc_init_s;
        a_r         <= a;
        out_valid_r <= 1'b0;
`ifdef ALU_DIV_EN
        div_r       <= (op == OP_DIVU);
        b_r         <= b;
`endif
      end else begin
        state_r     <= S_DONE;
        result_r    <= sc_result_s;
        zero_r      <= sc_zero_s;
        err_r       <= sc_err_s;
        out_valid_r <= 1'b1;
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          state_r <= S_IDLE;
        end
        S_BUSY: begin
          if (count_r == {CNT_W{1'b0}}) begin
            state_r     <= S_DONE;
            result_r    <= acc_r;
            zero_r      <= (acc_r == FULL_ZERO);
            err_r       <= 1'b0;
            out_valid_r <= 1'b1;
          end else begin
            acc_r   <= step_next_s;
            count_r <= count_r - CNT_ONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_r     <= S_IDLE;
            out_valid_r <= 1'b0;
          end else begin
            state_r <= S_DONE;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32); divider checks
// are compiled in when ALU_DIV_EN is defined.
module tb_alu_seq;

  localparam int W = 32;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  result;
  logic            zero;
  logic            err;

  int checks;
  int passed;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present one request for a single clock edge and return on the next negedge.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count cycles from the transfer edge until out_valid, checking in_ready stays low.
  task automatic wait_result(input string tag, output int lat);
    logic busy_rdy;
    busy_rdy = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_rdy = 1'b1;
      @(negedge clk);
      lat++;
    end
    check({tag, "_busy_in_ready"}, 64'(busy_rdy), 64'd0);
  endtask

  initial begin
    int lat;
    logic seen;
    checks = 0;
    passed = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op = 4'd0;
    a = 32'd0;
    b = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    issue(4'b0000, 32'hFFFF_FFFF, 32'h1);
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_result", result, 64'd0);
    check("add_zero", 64'(zero), 64'd1);
    check("add_err", 64'(err), 64'd0);
    @(negedge clk);
    check("idle_after_done", 64'(out_valid), 64'd0);

    issue(4'b0001, 32'd3, 32'd5);
    check("sub_result", result, 64'h0000_0000_FFFF_FFFE);
    check("sub_zero", 64'(zero), 64'd0);
    issue(4'b0110, 32'hFFFF_FFFF, 32'd1);
    check("slt_result", result, 64'd1);
    issue(4'b1001, 32'hFFFF_FFFF, 32'd1);
    check("sltu_result", result, 64'd0);
    check("sltu_zero", 64'(zero), 64'd1);
    issue(4'b0111, 32'h1234, 32'h1234);
    check("beq_zero", 64'(zero), 64'd1);
    check("beq_result", result, 64'd0);
    issue(4'b1000, 32'h1234, 32'h1234);
    check("bne_zero", 64'(zero), 64'd0);
    issue(4'b1111, 32'h5, 32'h5);
    check("ill_err", 64'(err), 64'd1);
    check("ill_result", result, 64'd0);
    check("ill_zero", 64'(zero), 64'd0);
    check("ill_valid", 64'(out_valid), 64'd1);
    @(negedge clk);

    // MULU with operand change after transfer
    issue(4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    a = 32'd0;
    b = 32'd0;
    wait_result("mulu", lat);
    check("mulu_latency", 64'(lat), 64'd33);
    check("mulu_result", result, 64'hFFFF_FFFE_0000_0001);
    check("mulu_err", 64'(err), 64'd0);
    @(negedge clk);

`ifdef ALU_DIV_EN
    issue(4'b1010, 32'd100, 32'd7);
    wait_result("divu", lat);
    check("divu_latency", 64'(lat), 64'd33);
    check("divu_result", result, 64'h0000_0002_0000_000E);
    check("divu_err", 64'(err), 64'd0);
    @(negedge clk);
    issue(4'b1010, 32'd5, 32'd0);
    wait_result("div0", lat);
    check("div0_result", result, 64'h0000_0005_FFFF_FFFF);
    check("div0_err", 64'(err), 64'd0);
    @(negedge clk);
`else
    issue(4'b1010, 32'd100, 32'd7);
    check("divu_ill_valid", 64'(out_valid), 64'd1);
    check("divu_ill_err", 64'(err), 64'd1);
    check("divu_ill_result", result, 64'd0);
    @(negedge clk);
`endif

    // Backpressure: hold the AND result while a competing request is offered
    out_ready = 1'b0;
    issue(4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00);
    check("and_result", result, 64'h0000_0000_F000_F000);
    in_valid = 1'b1;
    op = 4'b0101;
    a = 32'h1;
    b = 32'h2;
    for (int i = 0; i < 4; i++) begin
      check("hold_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_result", result, 64'h0000_0000_F000_F000);
      check("hold_zero", 64'(zero), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_valid", 64'(out_valid), 64'd0);

    // Back-to-back XOR stream
    in_valid = 1'b1;
    op = 4'b0101;
    a = 32'h1; b = 32'h3;
    @(negedge clk);
    check("xor0_valid", 64'(out_valid), 64'd1);
    check("xor0_result", result, 64'h2);
    a = 32'hFFFF_0000; b = 32'h0000_FFFF;
    @(negedge clk);
    check("xor1_valid", 64'(out_valid), 64'd1);
    check("xor1_result", result, 64'hFFFF_FFFF);
    a = 32'hAAAA_AAAA; b = 32'hAAAA_AAAA;
    @(negedge clk);
    check("xor2_result", result, 64'h0);
    check("xor2_zero", 64'(zero), 64'd1);
    a = 32'h1234_5678; b = 32'hFFFF_FFFF;
    @(negedge clk);
    check("xor3_valid", 64'(out_valid), 64'd1);
    check("xor3_result", result, 64'hEDCB_A987);
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_end_valid", 64'(out_valid), 64'd0);

    // Reset in the middle of a MULU
    issue(4'b0010, 32'd7, 32'd9);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_result", result, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_output", 64'(seen), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, multi-cycle successor to the single-cycle datapath ALU for the MIPS core.
- Adds valid/ready handshakes, registered outputs and an iterative unsigned multiplier.
- Adds signed and unsigned set-less-than, an illegal-op flag, and an optional iterative unsigned divider.
- Sits between decode/register-read and writeback; the multi-cycle control stalls on in_ready/out_valid.

Parameters:
WIDTH, 32, operand width in bits (>=4); result is 2*WIDTH bits.
CNT_W, $clog2(WIDTH)+1, width of the iteration counter (derived; do not override).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operation request.
in_ready  output  1  high when a request can be accepted.
op  input  4  operation select (see Behaviour).
a  input  WIDTH  operand 1.
b  input  WIDTH  operand 2.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts the result.
result  output  2*WIDTH  registered result.
zero  output  1  registered zero/branch flag.
err  output  1  registered illegal-opcode flag.

Behaviour:
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 MULU, 0011 AND, 0100 OR, 0101 XOR.
  - 0110 SLT (signed), 0111 BEQ, 1000 BNE, 1001 SLTU, 1010 DIVU.
  - All other codes are illegal.
- Reset: state=IDLE, out_valid=0, result=0, zero=0, err=0, counter=0. rst has priority over everything; in flight operations are aborted with no output.
- in_ready = (state==IDLE) | (state==DONE & out_ready). A transfer occurs when in_valid & in_ready.
- a, b and op are latched at transfer; later input changes are ignored.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, transfer, single-cycle op -> DONE. out_valid=1 on the next edge; latency 1.
  - IDLE, transfer, MULU/DIVU -> BUSY with counter=WIDTH. One shift-add or shift-subtract step per cycle.
  - BUSY, counter reaches 0 -> DONE. out_valid rises exactly WIDTH+1 cycles after the transfer edge.
  - DONE, out_ready=0 -> stay in DONE; result, zero and err are held stable.
  - DONE, out_ready=1, no new transfer -> IDLE; out_valid=0.
  - DONE, out_ready=1, new transfer -> handled as the IDLE-transfer case (back-to-back). Single-cycle ops sustain 1 op/cycle.
- in_valid during BUSY is not accepted (in_ready=0).
- Width and arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH; upper WIDTH bits of result = 0.
  - Logic ops are bitwise; upper half = 0.
  - MULU: full 2*WIDTH unsigned product.
  - SLT: two's-complement compare. SLTU: unsigned compare. Result is 1 or 0, zero-extended.
  - BEQ/BNE: result=0. zero=(a==b) for BEQ, zero=(a!=b) for BNE.
  - All other ops: zero=(result==0).
  - Illegal op: single-cycle, result=0, zero=0, err=1.
  - err=0 for every legal op.

Optional Feature:
ALU_DIV_EN
- Defined: DIVU is legal and multi-cycle (WIDTH+1 latency). Restoring division is used.
  - result[WIDTH-1:0] = quotient, result[2*WIDTH-1:WIDTH] = remainder.
  - Divide by zero: quotient = all ones, remainder = a, err=0.
- Undefined: no divider logic is built; 1010 is an illegal opcode (result=0, zero=0, err=1, latency 1).

Test Plan:
- Reset mid-MULU: accept a=7, b=9, assert rst on the 5th cycle -> next cycle out_valid=0, in_ready=1, result=0; no result is ever presented.
- WIDTH=32, ADD/SUB:
  - ADD a=0xFFFFFFFF, b=1 -> 1 cycle later out_valid=1, result=0, zero=1.
  - SUB a=3, b=5 -> result=0x00000000_FFFFFFFE, zero=0.
- MULU a=0xFFFFFFFF, b=0xFFFFFFFF -> out_valid exactly 33 cycles after transfer, result=0xFFFFFFFE_00000001.
  - in_ready=0 throughout BUSY.
- SLT/SLTU/branch:
  - SLT a=0xFFFFFFFF, b=1 -> result=1. SLTU with the same operands -> result=0.
  - BEQ a=b=0x1234 -> zero=1. BNE with the same operands -> zero=0.
- Backpressure and streaming:
  - Hold out_ready=0 for 4 cycles after an AND result -> result, zero and out_valid stay stable. in_ready=0 while held.
  - With out_ready=1, four back-to-back XOR ops -> four results on consecutive cycles.
- Opcode 1111 -> err=1, result=0. With ALU_DIV_EN defined:
  - DIVU a=100, b=7 -> quotient=14, remainder=2 after 33 cycles.
  - DIVU a=5, b=0 -> quotient=0xFFFFFFFF, remainder=5.
